// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS-subset core. Instructions and data share
// one valid/ready memory port, so any access may stall. Internal 32x32 register
// file with a combinational debug read port. Illegal opcodes park the core in TRAP.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        tb_add,
  output logic [31:0]       tb_da,
  output logic [31:0]       pc,
  output logic [31:0]       inst,
  output logic              trap
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  state_t      state, next_state;
  logic [31:0] regs [32];
  logic [31:0] a_reg, b_reg, alu_out, mdr, br_target;
  logic        run;
  logic [31:0] addr_full;
  logic        fire;

  // instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] sext_imm, zext_imm, rf_rs, rf_rt, jump_target;
  logic        legal_op, is_jr, take_branch;
  logic [31:0] alu_res;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  assign op          = inst[31:26];
  assign rs          = inst[25:21];
  assign rt          = inst[20:16];
  assign rd          = inst[15:11];
  assign shamt       = inst[10:6];
  assign funct       = inst[5:0];
  assign imm         = inst[15:0];
  assign sext_imm    = {{16{imm[15]}}, imm};
  assign zext_imm    = {16'h0000, imm};
  assign rf_rs       = regs[rs];
  assign rf_rt       = regs[rt];
  assign jump_target = {pc[31:28], inst[25:0], 2'b00};
  assign is_jr       = (op == OP_R) && (funct == F_JR);
  assign take_branch = ((op == OP_BEQ) && (a_reg == b_reg)) ||
                       ((op == OP_BNE) && (a_reg != b_reg));

  assign tb_da     = (tb_add == 5'd0) ? '0 : regs[tb_add];
  assign trap      = (state == TRAP);
  assign mem_wdata = b_reg;
  assign mem_addr  = addr_full[ADDR_W-1:0] & ~ADDR_W'(3);
  assign fire      = mem_req && mem_ready;

  // opcode legality check for DECODE
  always_comb begin
    legal_op = 1'b0;
    case (op)
      OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  // ALU: operates on the latched operands, result captured in EXEC
  always_comb begin
    alu_res = '0;
    case (op)
      OP_R: begin
        case (funct)
          F_ADD:   alu_res = a_reg + b_reg;
          F_SUB:   alu_res = a_reg - b_reg;
          F_AND:   alu_res = a_reg & b_reg;
          F_OR:    alu_res = a_reg | b_reg;
          F_SLT:   alu_res = {31'b0, $signed(a_reg) < $signed(b_reg)};
          F_SLL:   alu_res = b_reg << shamt;
          F_SRL:   alu_res = b_reg >> shamt;
          default: alu_res = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_res = a_reg + sext_imm;
      OP_ANDI:               alu_res = a_reg & zext_imm;
      OP_ORI:                alu_res = a_reg | zext_imm;
      OP_SLTI:               alu_res = {31'b0, $signed(a_reg) < $signed(sext_imm)};
      default:               alu_res = '0;
    endcase
  end

  // write-back destination and source; unknown R functs execute as nop
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rt;
    wr_data = alu_out;
    case (op)
      OP_R: begin
        wr_addr = rd;
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL: wr_en = 1'b1;
          default: wr_en = 1'b0;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: wr_en = 1'b1;
      OP_LW: begin
        wr_en   = 1'b1;
        wr_data = mdr;
      end
      default: wr_en = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // next-state and memory port control; run keeps the request low for the
  // first cycle after reset so a reset during a wait visibly drops mem_req
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_full  = pc;
    case (state)
      FETCH: begin
        mem_req = run;
        if (run && mem_ready) next_state = DECODE;
      end
      DECODE: begin
        if (!legal_op)                                  next_state = TRAP;
        else if ((op == OP_J) || (op == OP_JAL) || is_jr) next_state = FETCH;
        else                                            next_state = EXEC;
      end
      EXEC: begin
        if ((op == OP_BEQ) || (op == OP_BNE))    next_state = FETCH;
        else if ((op == OP_LW) || (op == OP_SW)) next_state = MEM;
        else                                     next_state = WB;
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = (op == OP_SW);
        addr_full = alu_out;
        if (mem_ready) next_state = (op == OP_SW) ? FETCH : WB;
      end
      WB:      next_state = FETCH;
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

  // datapath registers and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      inst      <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      br_target <= '0;
      run       <= 1'b0;
      regs      <= '{default: '0};
    end else begin
      run <= 1'b1;
      case (state)
        FETCH: begin
          if (fire) begin
            inst <= mem_rdata;
            pc   <= pc + 32'd4;
          end
        end
        DECODE: begin
          a_reg     <= rf_rs;
          b_reg     <= rf_rt;
          br_target <= pc + {sext_imm[29:0], 2'b00};
          if (op == OP_J) begin
            pc <= jump_target;
          end else if (op == OP_JAL) begin
            pc       <= jump_target;
            regs[31] <= pc;
          end else if (is_jr) begin
            pc <= rf_rs;
          end
        end
        EXEC: begin
          alu_out <= alu_res;
          if (take_branch) pc <= br_target;
        end
        MEM: begin
          if (fire && !mem_we) mdr <= mem_rdata;
        end
        WB: begin
          if (wr_en && (wr_addr != 5'd0)) regs[wr_addr] <= wr_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Testbench for mips_multicycle_core: directed vector table, multi-cycle corner
// sequences (waits, trap, reset mid-wait) and random programs against an ISA model.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  tb_add;
  logic [31:0] tb_da, pc, inst;
  logic        trap;

  int unsigned passed = 0;
  int unsigned total  = 0;

  mips_multicycle_core #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .tb_add(tb_add), .tb_da(tb_da), .pc(pc),
    .inst(inst), .trap(trap)
  );

  always #20 clk = ~clk;

  // memory: img is the loaded image, wmem/wvld overlay stores made since reset
  logic [31:0] img  [1024];
  logic [31:0] wmem [1024];
  logic        wvld [1024];
  int unsigned wait_cfg = 0;
  int unsigned wcnt = 0;
  int unsigned wr_count = 0;
  logic [31:0] last_waddr, last_wdata;
  logic [9:0]  midx;

  assign midx      = mem_addr[11:2];
  assign mem_rdata = wvld[midx] ? wmem[midx] : img[midx];
  assign mem_ready = mem_req && (wcnt >= wait_cfg);

  always @(posedge clk) begin
    if (reset) begin
      wcnt     <= 0;
      wr_count <= 0;
      for (int i = 0; i < 1024; i++) wvld[i] <= 1'b0;
    end else begin
      if (!mem_req || mem_ready) wcnt <= 0;
      else                       wcnt <= wcnt + 1;
      if (mem_req && mem_ready && mem_we) begin
        wmem[midx] <= mem_wdata;
        wvld[midx] <= 1'b1;
        wr_count   <= wr_count + 1;
        last_waddr <= mem_addr;
        last_wdata <= mem_wdata;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    tb_add = r;
    #1;
    v = tb_da;
  endtask

  // advance n cycles, checking that a pending request stays unchanged
  task automatic step_cycles(input int unsigned n);
    logic p_req, p_rdy, p_we, p_rst;
    logic [31:0] p_addr, p_wd;
    for (int unsigned i = 0; i < n; i++) begin
      p_req = mem_req; p_rdy = mem_ready; p_we = mem_we;
      p_addr = mem_addr; p_wd = mem_wdata; p_rst = reset;
      @(posedge clk);
      @(negedge clk);
      if (p_req && !p_rdy && !p_rst) begin
        check("hold_req", {31'b0, mem_req}, 32'd1);
        check("hold_addr", mem_addr, p_addr);
        check("hold_we", {31'b0, mem_we}, {31'b0, p_we});
        check("hold_wdata", mem_wdata, p_wd);
      end
    end
  endtask

  // 3 reset cycles, release, then one edge: ends on a negedge with the core fetching
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 32'h0;
  endtask

  // ISA-level reference model
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [1024];

  task automatic model_step(output int unsigned cost);
    logic [31:0] ins, a, b, se, ze, res, npc, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, wa;
    logic        wr;
    ins = m_mem[m_pc[11:2]];
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a = m_regs[rs]; b = m_regs[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    ea = a + se;
    npc = m_pc + 32'd4;
    wr = 1'b0; wa = rt; res = 32'h0;
    cost = 4 + wait_cfg;
    case (op)
      6'h00: begin
        wa = rd; wr = 1'b1;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h08: begin wr = 1'b0; npc = a; cost = 2 + wait_cfg; end
          default: wr = 1'b0;
        endcase
      end
      6'h08: begin wr = 1'b1; res = a + se; end
      6'h0C: begin wr = 1'b1; res = a & ze; end
      6'h0D: begin wr = 1'b1; res = a | ze; end
      6'h0A: begin wr = 1'b1; res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h23: begin wr = 1'b1; res = m_mem[ea[11:2]]; cost = 5 + 2 * wait_cfg; end
      6'h2B: begin m_mem[ea[11:2]] = b; cost = 4 + 2 * wait_cfg; end
      6'h04: begin cost = 3 + wait_cfg; if (a == b) npc = npc + (se << 2); end
      6'h05: begin cost = 3 + wait_cfg; if (a != b) npc = npc + (se << 2); end
      6'h02: begin cost = 2 + wait_cfg; npc = {npc[31:28], ins[25:0], 2'b00}; end
      6'h03: begin
        cost = 2 + wait_cfg; wr = 1'b1; wa = 5'd31; res = npc;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: cost = 2 + wait_cfg;
    endcase
    if (wr && (wa != 5'd0)) m_regs[wa] = res;
    m_pc = npc;
  endtask

  // random legal instruction using registers $0..$7, forward-only control flow
  function automatic logic [31:0] gen_ins(input logic [31:0] addr);
    logic [5:0]  fl [8];
    logic [5:0]  ol [4];
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] tgt;
    int unsigned kind;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h21};
    ol = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    kind = $urandom_range(0, 11);
    if (kind <= 5) begin
      fn = fl[$urandom_range(0, 7)];
      sh = ((fn == 6'h00) || (fn == 6'h02)) ? 5'($urandom_range(0, 31)) : 5'd0;
      return {6'h00, rs, rt, rd, sh, fn};
    end else if (kind <= 7) begin
      return {ol[$urandom_range(0, 3)], rs, rt, imm};
    end else if (kind == 8) begin
      return {6'h23, 5'd0, rt, 16'(32'h800 + 4 * $urandom_range(0, 15))};
    end else if (kind == 9) begin
      return {6'h2B, 5'd0, rt, 16'(32'h800 + 4 * $urandom_range(0, 15))};
    end else if (kind == 10) begin
      return {($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, rs, rt, 16'($urandom_range(0, 3))};
    end else begin
      tgt = addr + 32'd4 + 32'(4 * $urandom_range(0, 3));
      return {6'h02, tgt[27:2]};
    end
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ins;
    int unsigned cyc;
    logic [4:0]  rsel;
    logic [31:0] rval;
    logic [31:0] pc_exp;
  } vec_t;

  vec_t        vt [15];
  logic [31:0] v;

  initial begin
    reset  = 1'b1;
    tb_add = 5'd0;

    vt[0]  = '{32'h00, 32'h20010005, 4, 5'd1,  32'd5,        32'h04};
    vt[1]  = '{32'h04, 32'h20020007, 4, 5'd2,  32'd7,        32'h08};
    vt[2]  = '{32'h08, 32'h00221820, 4, 5'd3,  32'd12,       32'h0C};
    vt[3]  = '{32'h0C, 32'h00000000, 4, 5'd3,  32'd12,       32'h10};
    vt[4]  = '{32'h10, 32'h10210002, 3, 5'd1,  32'd5,        32'h1C};
    vt[5]  = '{32'h1C, 32'h14210002, 3, 5'd1,  32'd5,        32'h20};
    vt[6]  = '{32'h20, 32'h0C000010, 2, 5'd31, 32'h24,       32'h40};
    vt[7]  = '{32'h40, 32'h03E00008, 2, 5'd31, 32'h24,       32'h24};
    vt[8]  = '{32'h24, 32'h20000009, 4, 5'd0,  32'd0,        32'h28};
    vt[9]  = '{32'h28, 32'h00611822, 4, 5'd3,  32'd7,        32'h2C};
    vt[10] = '{32'h2C, 32'h0022202A, 4, 5'd4,  32'd1,        32'h30};
    vt[11] = '{32'h30, 32'h00022900, 4, 5'd5,  32'h70,       32'h34};
    vt[12] = '{32'h34, 32'h34068000, 4, 5'd6,  32'h8000,     32'h38};
    vt[13] = '{32'h38, 32'h2007FFFF, 4, 5'd7,  32'hFFFFFFFF, 32'h3C};
    vt[14] = '{32'h3C, 32'h00074702, 4, 5'd8,  32'h0000000F, 32'h40};

    // reset state and first fetch
    clear_img();
    for (int i = 0; i < 15; i++) img[vt[i].addr[11:2]] = vt[i].ins;
    wait_cfg = 0;
    @(negedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("first_req", {31'b0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
    check("first_we", {31'b0, mem_we}, 32'd0);
    check("first_trap", {31'b0, trap}, 32'd0);

    // directed vector table, zero-wait memory
    for (int i = 0; i < 15; i++) begin
      step_cycles(vt[i].cyc);
      check($sformatf("vec%0d_pc", i), pc, vt[i].pc_exp);
      read_reg(vt[i].rsel, v);
      check($sformatf("vec%0d_reg", i), v, vt[i].rval);
    end

    // store then load with three wait cycles per request
    clear_img();
    img[0] = 32'h2003000C;
    img[1] = 32'hAC030004;
    img[2] = 32'h8C040004;
    wait_cfg = 3;
    do_reset();
    step_cycles(7);
    check("w_addi_pc", pc, 32'h4);
    read_reg(5'd3, v);
    check("w_addi_r3", v, 32'd12);
    step_cycles(10);
    check("w_sw_pc", pc, 32'h8);
    check("w_sw_count", 32'(wr_count), 32'd1);
    check("w_sw_addr", last_waddr, 32'h4);
    check("w_sw_data", last_wdata, 32'd12);
    step_cycles(11);
    check("w_lw_pc", pc, 32'hC);
    read_reg(5'd4, v);
    check("w_lw_r4", v, 32'd12);
    check("w_lw_count", 32'(wr_count), 32'd1);

    // illegal opcode traps and stays there
    clear_img();
    img[0] = 32'hFC000000;
    wait_cfg = 0;
    do_reset();
    step_cycles(2);
    for (int i = 0; i < 10; i++) begin
      check("trap_flag", {31'b0, trap}, 32'd1);
      check("trap_req", {31'b0, mem_req}, 32'd0);
      check("trap_pc", pc, 32'h4);
      step_cycles(1);
    end

    // reset clears trap; then reset in the middle of a load wait
    clear_img();
    img[0] = 32'h8C040004;
    img[1] = 32'h00000055;
    wait_cfg = 3;
    do_reset();
    check("trap_cleared", {31'b0, trap}, 32'd0);
    step_cycles(7);
    check("mw_req", {31'b0, mem_req}, 32'd1);
    check("mw_addr", mem_addr, 32'h4);
    check("mw_we", {31'b0, mem_we}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mw_rst_req", {31'b0, mem_req}, 32'd0);
    check("mw_rst_pc", pc, 32'h0);
    check("mw_rst_trap", {31'b0, trap}, 32'd0);
    reset = 1'b0;

    // random programs against the ISA model, varied memory latency
    for (int unsigned w = 0; w < 3; w++) begin
      int unsigned cost;
      clear_img();
      for (int k = 0; k < 64; k++) img[512 + k] = $urandom;
      for (int k = 1; k < 8; k++) img[k - 1] = {6'h08, 5'd0, 5'(k), 16'($urandom)};
      for (int k = 7; k < 64; k++) img[k] = gen_ins(32'(4 * k));
      for (int k = 0; k < 1024; k++) m_mem[k] = img[k];
      for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
      m_pc = 32'h0;
      wait_cfg = w;
      do_reset();
      for (int s = 0; s < 60; s++) begin
        model_step(cost);
        step_cycles(cost);
        check($sformatf("rnd%0d_s%0d_pc", w, s), pc, m_pc);
        for (int r = 0; r < 8; r++) begin
          read_reg(5'(r), v);
          check($sformatf("rnd%0d_s%0d_r%0d", w, s, r), v, m_regs[r]);
        end
      end
      for (int k = 512; k < 576; k++)
        check($sformatf("rnd%0d_mem%0d", w, k), wvld[k] ? wmem[k] : img[k], m_mem[k]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
